// File: rtl/game_state_tx_mux.sv
// Frame sequencer: snapshots game state on a frame trigger and offers five
// tagged 16-bit words, one per converter handshake, to the UART path.
module game_state_tx_mux #(
    parameter int TIMEOUT = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    input  logic [3:0]  pl1_score,
    input  logic [3:0]  pl2_score,
    input  logic        flag_point,
    input  logic        end_game,
    input  logic        conv16to8ready,
    input  logic        tx_done,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OFFER, WAIT_DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt, idx_inc;
    logic            pending, pending_nxt;
    logic [CW-1:0]   tcnt;
    logic            load_snap;
    logic [15:0]     data_nxt, next_word;

    // coherent copy of the game state taken when a frame starts
    logic [11:0]     s_p1x, s_p1y, s_bx, s_by;
    logic [3:0]      s_sc1, s_sc2;
    logic            s_fp, s_eg;

    assign busy       = (state != IDLE);
    assign data_valid = (state == OFFER);
    assign idx_inc    = idx + 3'd1;

    // Word that follows the current index, built from the snapshot only
    always_comb begin
        case (idx_inc)
            3'd1:    next_word = {4'd2, s_p1y};
            3'd2:    next_word = {4'd3, s_bx};
            3'd3:    next_word = {4'd4, s_by};
            default: next_word = {4'd5, s_sc1, s_sc2, 2'b00, s_fp, s_eg};
        endcase
    end

    // Next-state, trigger queuing and pulse outputs
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        load_snap   = 1'b0;
        data_nxt    = data;
        timeout_err = 1'b0;
        // a tick arriving while one is already queued is always lost
        overrun     = frame_tick & pending;
        case (state)
            IDLE: begin
                if (frame_tick || pending) begin
                    load_snap   = 1'b1;
                    idx_nxt     = 3'd0;
                    pending_nxt = 1'b0;
                    // word 1 comes from the live inputs, identical to the snapshot
                    data_nxt    = {4'd1, pl1_posx};
                    state_nxt   = OFFER;
                end
            end
            OFFER: begin
                if (frame_tick && !pending)
                    pending_nxt = 1'b1;
                if (conv16to8ready)
                    state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (frame_tick && !pending)
                    pending_nxt = 1'b1;
                if (tx_done) begin
                    if (idx == 3'd4) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx_inc;
                        data_nxt  = next_word;
                        state_nxt = OFFER;
                    end
                end else if (tcnt == TMAX) begin
                    timeout_err = 1'b1;
                    pending_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, index, queued trigger and offered word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= 3'd0;
            pending <= 1'b0;
            data    <= 16'd0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            pending <= pending_nxt;
            data    <= data_nxt;
        end
    end

    // Saturating wait counter, held at zero outside WAIT_DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt <= '0;
        else if (state != WAIT_DONE)
            tcnt <= '0;
        else if (tcnt != {CW{1'b1}})
            tcnt <= tcnt + 1'b1;
    end

    // Snapshot registers, loaded only as the frame leaves IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_p1x <= '0; s_p1y <= '0; s_bx <= '0; s_by <= '0;
            s_sc1 <= '0; s_sc2 <= '0; s_fp <= 1'b0; s_eg <= 1'b0;
        end else if (load_snap) begin
            s_p1x <= pl1_posx;  s_p1y <= pl1_posy;
            s_bx  <= ball_posx; s_by  <= ball_posy;
            s_sc1 <= pl1_score; s_sc2 <= pl2_score;
            s_fp  <= flag_point; s_eg <= end_game;
        end
    end
endmodule

// File: tb/tb_game_state_tx_mux.sv
// Directed bench for game_state_tx_mux: cycle-exact checks of frame order,
// snapshot coherence, backpressure, queuing, timeout and async reset.
module tb_game_state_tx_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick, conv16to8ready, tx_done;
    logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
    logic [3:0]  pl1_score, pl2_score;
    logic        flag_point, end_game;
    logic [15:0] data;
    logic        data_valid, busy, overrun, timeout_err;

    int checks = 0;
    int errors = 0;

    game_state_tx_mux #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
        .ball_posx(ball_posx), .ball_posy(ball_posy),
        .pl1_score(pl1_score), .pl2_score(pl2_score),
        .flag_point(flag_point), .end_game(end_game),
        .conv16to8ready(conv16to8ready), .tx_done(tx_done),
        .data(data), .data_valid(data_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change on the falling edge; checks follow 1 time unit later
    task automatic cyc();
        @(negedge clk);
    endtask

    // Entered on the cycle the word must be on offer (ready already 1).
    // Checks the word, waits dly cycles from acceptance, pulses tx_done,
    // and returns on the cycle after tx_done. Optional mid-wait ticks.
    task automatic xfer(input logic [15:0] exp, input int dly, input string tag, input int ntick);
        #1;
        chk({tag, " valid"}, data_valid, 1);
        chk({tag, " data"}, data, exp);
        for (int i = 1; i < dly; i++) begin
            cyc();
            frame_tick = (ntick >= 1 && i == 2) || (ntick >= 2 && i == 4);
            #1;
            if (i == 1) chk({tag, " valid drop"}, data_valid, 0);
            if (ntick >= 1 && i == 2) chk("overrun first tick", overrun, 0);
            if (ntick >= 2 && i == 4) chk("overrun second tick", overrun, 1);
            if (ntick >= 2 && i == 5) chk("overrun single pulse", overrun, 0);
        end
        cyc();
        frame_tick = 1'b0;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
    endtask

    task automatic start_frame();
        cyc();
        frame_tick = 1'b1;
        #1;
        chk("idle busy before tick", busy, 0);
        cyc();
        frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        rst = 1'b0; frame_tick = 1'b0; conv16to8ready = 1'b0; tx_done = 1'b0;
        pl1_posx = 12'd100; pl1_posy = 12'd600; ball_posx = 12'd512; ball_posy = 12'd200;
        pl1_score = 4'd3; pl2_score = 4'd7; flag_point = 1'b1; end_game = 1'b0;

        repeat (3) cyc();
        #1;
        chk("reset outputs", {data, data_valid, busy, overrun, timeout_err}, 0);
        cyc();
        rst = 1'b1;
        conv16to8ready = 1'b1;
        cyc(); #1;
        chk("idle after reset", {data, data_valid, busy}, 0);

        // single frame
        start_frame();
        #0 chk("busy at n+1", busy, 1);
        xfer(16'h1064, 20, "f1w1", 0);
        // ball moves after word 1 accepted; frame keeps its snapshot
        ball_posx = 12'd700;
        xfer(16'h2258, 20, "f1w2", 0);
        xfer(16'h3200, 20, "f1w3", 0);
        xfer(16'h40C8, 20, "f1w4", 0);
        xfer(16'h5372, 20, "f1w5", 0);
        #1;
        chk("busy low after last done", busy, 0);
        chk("valid low after frame", data_valid, 0);
        chk("data holds last word", data, 16'h5372);

        // next frame sees new ball_posx; backpressure on word 2
        start_frame();
        xfer(16'h1064, 20, "f2w1", 0);
        conv16to8ready = 1'b0;
        ok = 1'b1;
        for (int j = 0; j < 50; j++) begin
            if (j != 0) cyc();
            #1;
            if (!(data_valid === 1'b1 && data === 16'h2258)) ok = 1'b0;
        end
        chk("backpressure hold", ok, 1);
        cyc();
        conv16to8ready = 1'b1;
        xfer(16'h2258, 20, "f2w2", 0);
        xfer(16'h32BC, 20, "f2w3", 0);
        xfer(16'h40C8, 20, "f2w4", 0);
        xfer(16'h5372, 20, "f2w5", 0);

        // queuing: two ticks during word 2 wait, exactly two frames
        start_frame();
        xfer(16'h1064, 20, "f3w1", 0);
        xfer(16'h2258, 20, "f3w2", 2);
        xfer(16'h32BC, 20, "f3w3", 0);
        xfer(16'h40C8, 20, "f3w4", 0);
        xfer(16'h5372, 20, "f3w5", 0);
        #1;
        chk("one idle cycle between frames", busy, 0);
        cyc();
        xfer(16'h1064, 20, "f4w1", 0);
        xfer(16'h2258, 20, "f4w2", 0);
        xfer(16'h32BC, 20, "f4w3", 0);
        xfer(16'h40C8, 20, "f4w4", 0);
        xfer(16'h5372, 20, "f4w5", 0);
        ok = 1'b1;
        for (int j = 0; j < 30; j++) begin
            if (j != 0) cyc();
            #1;
            if (busy !== 1'b0 || data_valid !== 1'b0) ok = 1'b0;
        end
        chk("no third frame", ok, 1);

        // timeout: word 1 accepted, tx_done never arrives
        start_frame();
        #1;
        chk("to w1 data", data, 16'h1064);
        ok = 1'b1;
        for (int k = 1; k < 100; k++) begin
            cyc(); #1;
            if (timeout_err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        chk("no early timeout", ok, 1);
        cyc(); #1;
        chk("timeout pulse", timeout_err, 1);
        cyc(); #1;
        chk("busy after timeout", busy, 0);
        chk("timeout single pulse", timeout_err, 0);

        // restart at tag 1, then reset during word 3 wait
        start_frame();
        xfer(16'h1064, 20, "f5w1", 0);
        xfer(16'h2258, 20, "f5w2", 0);
        #1;
        chk("f5w3 data", data, 16'h32BC);
        repeat (5) cyc();
        #2 rst = 1'b0;
        #1;
        chk("async reset outputs", {data, data_valid, busy, overrun, timeout_err}, 0);
        cyc();
        rst = 1'b1;
        ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cyc(); #1;
            if ({data, data_valid, busy, overrun, timeout_err} !== 20'd0) ok = 1'b0;
        end
        chk("idle after reset release", ok, 1);
        start_frame();
        xfer(16'h1064, 20, "f6w1", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_state_tx_mux.md
# game_state_tx_mux

Host-side (player 1 board) frame sequencer that packs authoritative game state into tagged 16-bit words for the UART 16-to-8 converter. It is the transmitting counterpart to the player-2 board's `uart_demux`. It runs in the 65 MHz pixel clock domain between the game-logic block and `uart`. Each frame trigger snapshots the state and sends five words in a fixed order, one word per UART handshake.

## Interface
Parameters:
- `TIMEOUT`, default 2000000: maximum cycles to wait for `tx_done` after a word is accepted before the frame is aborted.

Ports:
- `clk` input 1: system clock (`clk65MHz`).
- `rst` input 1: reset, asynchronous, active-low.
- `frame_tick` input 1: one-cycle pulse that requests a frame (driven from vsync).
- `pl1_posx`, `pl1_posy` input 12 each: player-1 position.
- `ball_posx`, `ball_posy` input 12 each: ball position.
- `pl1_score`, `pl2_score` input 4 each: scores, 0..15.
- `flag_point`, `end_game` input 1 each: last-touch flag and game-over flag.
- `conv16to8ready` input 1: converter can accept a word.
- `tx_done` input 1: one-cycle pulse when both bytes of the accepted word have left the UART.
- `data` output 16: word to the converter.
- `data_valid` output 1: `data` holds a word on offer.
- `busy` output 1: a frame is in progress.
- `overrun` output 1: one-cycle pulse when a `frame_tick` is dropped.
- `timeout_err` output 1: one-cycle pulse when a frame is aborted.

## Operation
- Word format is `{tag[3:0], payload[11:0]}`. Tag 0 is never sent.
  - Word 1: tag 1, `pl1_posx`.
  - Word 2: tag 2, `pl1_posy`.
  - Word 3: tag 3, `ball_posx`.
  - Word 4: tag 4, `ball_posy`.
  - Word 5: tag 5, `{pl1_score, pl2_score, 2'b00, flag_point, end_game}`.
- Snapshot: on the cycle the FSM leaves IDLE, all inputs are registered together. Every word of a frame comes from that one coherent snapshot. Input changes during the frame are ignored.
- FSM states:
  - IDLE: `busy`=0. On `frame_tick` or `pending`: take the snapshot, word index = 0, clear `pending`, go to OFFER.
  - OFFER: `data_valid`=1 and `data`=word[index]. When `conv16to8ready`=1 the word is accepted that cycle: drop `data_valid` next cycle, clear the timeout counter, go to WAIT_DONE.
  - WAIT_DONE: on `tx_done`, if index = 4 go to IDLE, else increment index and go to OFFER. If the timeout counter reaches `TIMEOUT`-1 first, pulse `timeout_err`, clear `pending`, go to IDLE.
- Trigger queuing:
  - `frame_tick` while `busy` sets `pending`, so at most one frame is queued.
  - A `frame_tick` while `pending` is already set is dropped and pulses `overrun`.
- `tx_done` in IDLE or OFFER is ignored. A `frame_tick` coinciding with the last `tx_done` sets `pending`, and the next frame starts after one IDLE cycle.
- `data` holds its last value when `data_valid`=0.

## Timing
- Reset values: `data`=0, `data_valid`=0, `busy`=0, `overrun`=0, `timeout_err`=0, `pending`=0, FSM in IDLE, snapshot registers 0.
- Reset asserted mid-frame returns everything to the reset values immediately. No partial word resumes after release.
- Latency: `frame_tick` high in cycle n gives `data_valid`=1 with word 1 in cycle n+1, and `busy`=1 from cycle n+1.
- Handshake: the word is accepted in the first cycle with `data_valid`=1 and `conv16to8ready`=1. `data` must not change while `data_valid`=1.
- After `tx_done` in cycle m, the next word is offered in cycle m+1. On the fifth `tx_done`, `busy`=0 in cycle m+1.
- Timeout counter: ⌈log2(TIMEOUT)⌉ bits, saturating, active only in WAIT_DONE.

## Test plan
- Single frame: pl1=(100,600), ball=(512,200), scores 3/7, flag_point=1, end_game=0, ready tied 1, `tx_done` 20 cycles after each accept -> words 0x1064, 0x2258, 0x3200, 0x40C8, 0x5372 in order. `busy` low one cycle after the fifth `tx_done`.
- Snapshot coherence: change `ball_posx` to 700 after word 1 is accepted -> word 3 is still 0x3200. The next frame carries 0x32BC.
- Backpressure: hold `conv16to8ready`=0 for 50 cycles during word 2 -> `data_valid` stays 1 and `data` stays 0x2258, and the word is accepted on the first ready cycle.
- Queuing: two `frame_tick` pulses mid-frame -> first sets `pending`, second pulses `overrun` once. Exactly two frames are sent back-to-back.
- Timeout with `TIMEOUT`=100: no `tx_done` after word 1 -> `timeout_err` pulses 100 cycles after acceptance, `busy`=0, and the next tick restarts at tag 1.
- Async reset asserted during WAIT_DONE of word 3 -> all outputs 0 without a clock edge. After release, the idle outputs remain 0 until `frame_tick`.
